// File: rtl/posit_pkg.sv
// Shared posit<32,3> constants, FSM state encoding and the encoder bit-stream builder.
package posit_pkg;

  localparam int unsigned N  = 32;
  localparam int unsigned ES = 3;

  localparam logic [N-1:0] NAR    = 32'h8000_0000;
  localparam logic [N-1:0] MAXPOS = 32'h7FFF_FFFF;
  localparam logic [N-1:0] MINPOS = 32'h0000_0001;

  // Longest stream: 33 regime bits (k=31 or k=-32) + 3 exponent + 32 fraction, padded.
  localparam int unsigned StreamW = 72;

  typedef enum logic [2:0] {
    StIdle,
    StBuild,
    StRound,
    StSign,
    StDone
  } posit_state_e;

  // Regime run + terminator, then exponent, then fraction, MSB-first and left-aligned.
  function automatic logic [StreamW-1:0] build_stream(input logic [5:0]    k,
                                                      input logic [ES-1:0] exp_value,
                                                      input logic [N-1:0]  mantissa);
    logic signed [5:0]    ks;
    logic [StreamW-1:0]   tail;
    logic [StreamW-1:0]   ones;
    int                   run;
    ks = signed'(k);
    if (ks >= 0) begin
      run  = int'(ks) + 1;
      tail = {1'b0, exp_value, mantissa, 36'b0};
      ones = ~({StreamW{1'b1}} >> run);
      build_stream = ones | (tail >> run);
    end else begin
      run  = -int'(ks);
      tail = {1'b1, exp_value, mantissa, 36'b0};
      build_stream = tail >> run;
    end
  endfunction

endpackage

// File: rtl/posit_round_rne.sv
// Round-to-nearest-even of a 31-bit posit body with maxpos/minpos saturation.
module posit_round_rne
  import posit_pkg::*;
(
  input  logic [30:0] body_i,
  input  logic        guard_i,
  input  logic        sticky_i,
  input  logic [5:0]  k_i,
  output logic [30:0] body_o
);

  logic signed [5:0] k_s;
  logic              round_up;
  logic [31:0]       sum;

  always_comb begin
    k_s      = signed'(k_i);
    round_up = guard_i & (sticky_i | body_i[0]);
    sum      = {1'b0, body_i} + {31'b0, round_up};
    if (k_s >= 6'sd30) begin
      body_o = MAXPOS[30:0];
    end else if (k_s <= -6'sd31) begin
      body_o = MINPOS[30:0];
    end else if (sum[31]) begin
      body_o = MAXPOS[30:0];
    end else if (sum[30:0] == 31'd0) begin
      // A nonzero value never rounds to zero.
      body_o = MINPOS[30:0];
    end else begin
      body_o = sum[30:0];
    end
  end

endmodule

// File: rtl/posit_encoder.sv
// Multi-cycle posit<32,3> encoder: bit-serial body assembly, RNE rounding, sign application.
module posit_encoder
  import posit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sign,
  input  logic [5:0]    k,
  input  logic [ES-1:0] exp_value,
  input  logic [N-1:0]  mantissa,
  input  logic          zero_in,
  input  logic          nar_in,
  output logic          done,
  output logic [N-1:0]  posit_num
);

  posit_state_e       state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [StreamW-1:0] stream_q, stream_d;
  logic [30:0]        body_q, body_d;
  logic               guard_q, guard_d;
  logic               sticky_q, sticky_d;
  logic               sign_q, sign_d;
  logic [5:0]         k_q, k_d;
  logic               zero_q, zero_d;
  logic               nar_q, nar_d;
  logic [N-1:0]       posit_q, posit_d;
  logic               done_q, done_d;
  logic [30:0]        body_rounded;
  logic [N-1:0]       mag;

  posit_round_rne u_round (
    .body_i   (body_q),
    .guard_i  (guard_q),
    .sticky_i (sticky_q),
    .k_i      (k_q),
    .body_o   (body_rounded)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stream_d = stream_q;
    body_d   = body_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    sign_d   = sign_q;
    k_d      = k_q;
    zero_d   = zero_q;
    nar_d    = nar_q;
    posit_d  = posit_q;
    mag      = {1'b0, body_q};

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sign_d   = sign;
          k_d      = k;
          zero_d   = zero_in;
          nar_d    = nar_in;
          stream_d = build_stream(k, exp_value, mantissa);
          body_d   = '0;
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          cnt_d    = '0;
          state_d  = StBuild;
        end
      end
      StBuild: begin
        body_d   = {body_q[29:0], stream_q[StreamW-1]};
        stream_d = stream_q << 1;
        if (cnt_q == 5'd30) begin
          // Bit 70 becomes the guard once bit 71 has been shifted into the body.
          guard_d  = stream_q[StreamW-2];
          sticky_d = |stream_q[StreamW-3:0];
          state_d  = StRound;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StRound: begin
        body_d  = body_rounded;
        state_d = StSign;
      end
      StSign: begin
        if (nar_q) begin
          posit_d = NAR;
        end else if (zero_q) begin
          posit_d = '0;
        end else begin
          posit_d = sign_q ? (~mag + 32'd1) : mag;
        end
        state_d = StDone;
      end
      StDone: begin
        if (!start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered so done rises one edge after DONE is entered.
    done_d = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      stream_q <= '0;
      body_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      sign_q   <= 1'b0;
      k_q      <= '0;
      zero_q   <= 1'b0;
      nar_q    <= 1'b0;
      posit_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stream_q <= stream_d;
      body_q   <= body_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      sign_q   <= sign_d;
      k_q      <= k_d;
      zero_q   <= zero_d;
      nar_q    <= nar_d;
      posit_q  <= posit_d;
      done_q   <= done_d;
    end
  end

  assign done      = done_q;
  assign posit_num = posit_q;

endmodule

// File: tb/tb_posit_encoder.sv
// Scoreboard bench for posit_encoder: directed and random fields against a bit-list reference.
module tb_posit_encoder;

  localparam int Latency = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [5:0]  k = '0;
  logic [2:0]  exp_value = '0;
  logic [31:0] mantissa = '0;
  logic        zero_in = 1'b0;
  logic        nar_in = 1'b0;
  logic        done;
  logic [31:0] posit_num;

  int compared = 0;
  int mismatched = 0;
  int edge_cnt = 0;
  logic done_prev = 1'b0;

  logic [31:0] exp_q[$];
  int          acc_q[$];

  posit_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sign      (sign),
    .k         (k),
    .exp_value (exp_value),
    .mantissa  (mantissa),
    .zero_in   (zero_in),
    .nar_in    (nar_in),
    .done      (done),
    .posit_num (posit_num)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: spell out the stream as a list of bits, then round with integer arithmetic.
  function automatic logic [31:0] model(input logic s, input logic [5:0] kf, input logic [2:0] e,
                                        input logic [31:0] m, input logic z, input logic n);
    bit          bits[$];
    int          kk;
    longint      body;
    bit          guard;
    bit          sticky;
    logic [31:0] r;
    kk = int'($signed(kf));
    if (n) return 32'h8000_0000;
    if (z) return 32'h0000_0000;
    if (kk >= 0) begin
      repeat (kk + 1) bits.push_back(1'b1);
      bits.push_back(1'b0);
    end else begin
      repeat (-kk) bits.push_back(1'b0);
      bits.push_back(1'b1);
    end
    for (int i = 2; i >= 0; i--) bits.push_back(e[i]);
    for (int i = 31; i >= 0; i--) bits.push_back(m[i]);
    body = 0;
    for (int i = 0; i < 31; i++) body = body * 2 + longint'(bits[i]);
    guard  = bits[31];
    sticky = 1'b0;
    for (int i = 32; i < bits.size(); i++) sticky = sticky | bits[i];
    if (kk >= 30) begin
      body = 64'h7FFF_FFFF;
    end else if (kk <= -31) begin
      body = 1;
    end else begin
      if (guard && (sticky || (body % 2 == 1))) body = body + 1;
      if (body > 64'h7FFF_FFFF) body = 64'h7FFF_FFFF;
      if (body == 0) body = 1;
    end
    r = body[31:0];
    return s ? (~r + 32'd1) : r;
  endfunction

  // Monitor: every rising edge of done retires the oldest expectation.
  always @(negedge clk) begin
    if (rst && done && !done_prev) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1, expected no pending result (t=%0t)", $time);
      end else begin
        check("result", posit_num, exp_q.pop_front());
        check("latency", 32'(edge_cnt - acc_q.pop_front()), 32'(Latency));
      end
    end
    done_prev <= done;
  end

  task automatic issue(input logic s, input logic [5:0] kf, input logic [2:0] e,
                       input logic [31:0] m, input logic z, input logic n);
    @(negedge clk);
    sign = s; k = kf; exp_value = e; mantissa = m; zero_in = z; nar_in = n;
    start = 1'b1;
    exp_q.push_back(model(s, kf, e, m, z, n));
    acc_q.push_back(edge_cnt + 1);
  endtask

  task automatic run_op(input logic s, input logic [5:0] kf, input logic [2:0] e,
                        input logic [31:0] m, input logic z, input logic n, input int hold);
    logic [31:0] req;
    int          waited;
    req = model(s, kf, e, m, z, n);
    issue(s, kf, e, m, z, n);
    @(negedge clk);
    // Scramble inputs after acceptance; the encoder must ignore them.
    sign = 1'($urandom); k = 6'($urandom); exp_value = 3'($urandom); mantissa = $urandom;
    zero_in = 1'($urandom); nar_in = 1'($urandom);
    start = (hold > 0);
    waited = 0;
    while (!done && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!done) begin
      check("done_timeout", {31'b0, done}, 32'd1);
      void'(exp_q.pop_front());
      void'(acc_q.pop_front());
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("done_held", {31'b0, done}, 32'd1);
      check("value_held", posit_num, req);
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("done_fall", {31'b0, done}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_posit", posit_num, 32'd0);
    rst = 1'b1;

    run_op(1'b0, 6'b111101, 3'd5, 32'hCCCC_CC00, 1'b0, 1'b0, 0);
    run_op(1'b1, 6'b111101, 3'd5, 32'hCCCC_CC00, 1'b0, 1'b0, 2);
    run_op(1'b0, 6'd0, 3'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    run_op(1'b0, 6'd0, 3'd0, 32'h0000_0020, 1'b0, 1'b0, 0);
    run_op(1'b0, 6'd0, 3'd0, 32'h0000_0060, 1'b0, 1'b0, 1);
    run_op(1'b0, 6'd30, 3'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    run_op(1'b0, 6'd31, 3'd2, 32'h1234_5678, 1'b0, 1'b0, 0);
    run_op(1'b1, 6'd31, 3'd2, 32'h1234_5678, 1'b0, 1'b0, 0);
    run_op(1'b0, 6'b100001, 3'd0, 32'h0000_0000, 1'b0, 1'b0, 0);
    run_op(1'b0, 6'b100000, 3'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    run_op(1'b0, 6'b100010, 3'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    run_op(1'b1, 6'd5, 3'd3, 32'hDEAD_BEEF, 1'b1, 1'b0, 0);
    run_op(1'b0, 6'd5, 3'd3, 32'hDEAD_BEEF, 1'b1, 1'b1, 3);

    // Reset in the middle of BUILD abandons the operation.
    issue(1'b0, 6'd2, 3'd1, 32'hAAAA_5555, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    @(negedge clk);
    rst = 1'b1;
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_posit", posit_num, 32'd0);
    repeat (45) @(negedge clk);
    check("abort_quiet", {31'b0, done}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom), 6'($urandom), 3'($urandom), $urandom,
             ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
             int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
